// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller: FSM state
// encoding and the counter-width helper.
package serial_sub_ctrl_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One extra bit so that WIDTH=1 still yields a non-empty counter.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// 1-bit full subtractor: i_a - i_b - i_bin.
module full_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_borr
);
  assign o_diff = i_a ^ i_b ^ i_bin;
  assign o_borr = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first,
// WIDTH shift cycles per operation followed by a one-cycle done pulse.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = cnt_w(WIDTH);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res, w_res_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;
  logic             w_diff, w_borr, w_last;

  full_sub_cell u_cell (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_bin (r_brw),
    .o_diff(w_diff),
    .o_borr(w_borr)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // The result register fills from the top; a 1-bit result has no tail to keep.
  generate
    if (WIDTH == 1) begin : g_res1
      assign w_res_nxt = w_diff;
    end else begin : g_resn
      assign w_res_nxt = {w_diff, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_brw      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_res  <= w_res_nxt;
          r_brw  <= w_borr;
          r_cnt  <= r_cnt + 1'b1;
          // Results publish only here, so they stay stable across a new start.
          if (w_last) begin
            diff       <= w_res_nxt;
            borrow_out <= w_borr;
            done       <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
